// File: rtl/data_mem_stream_loader.sv
// -----------------------------------------------------------------------------
// data_mem_stream_loader
//
// Avalon-MM master in front of the single-port on-chip data memory (s1 port).
// It accepts FILL and DUMP commands from the test controller.
//   FILL : writes an incoming 32-bit word stream into consecutive memory words.
//   DUMP : reads consecutive memory words (1-cycle read latency) and presents
//          them as an outgoing stream through a 2-entry buffer that absorbs
//          downstream backpressure.
//
// Ports
//   clk, reset          : single clock, asynchronous active-high reset
//   cmd_*               : command handshake (write=1 FILL, base, len)
//   in_valid/ready/data : fill stream (sink)
//   out_valid/ready/data: dump stream (source)
//   mem_*               : Avalon-MM master towards the memory s1 slave
//   busy                : command in progress (state != IDLE)
//   done / err          : one-cycle completion / rejection pulses
// -----------------------------------------------------------------------------
module data_mem_stream_loader #(
    parameter int DEPTH = 6144,
    parameter int AW    = 13,
    parameter int LW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_base,
    input  logic [LW-1:0] cmd_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [AW-1:0] mem_address,
    output logic [3:0]    mem_byteenable,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    output logic          mem_clken,
    input  logic [31:0]   mem_readdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int EW = LW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DUMP  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_rem;
    logic          r_done;
    logic          r_err;
    logic          r_inflight;
    logic [31:0]   r_fifo [0:1];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    logic [EW-1:0] w_end;
    logic          w_range_bad;
    logic          w_len_zero;
    logic          w_cmd_acc;
    logic          w_fill_acc;
    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_occ_eff;
    logic          w_rd_issue;
    logic          w_drained;
    logic          w_done_next;
    logic          w_err_next;
    logic          w_load;
    logic          w_rem_last;

    // Range check is done one bit wider than the length so base+len cannot wrap.
    assign w_end       = EW'(cmd_base) + EW'(cmd_len);
    assign w_range_bad = (w_end > EW'(DEPTH));
    assign w_len_zero  = (cmd_len == {LW{1'b0}});
    assign w_rem_last  = (r_rem == {{(LW-1){1'b0}}, 1'b1});

    // cmd_ready is forced low while reset is held so every output reads idle.
    assign cmd_ready  = (r_state == ST_IDLE) & ~reset;
    assign w_cmd_acc  = cmd_valid & cmd_ready;
    assign in_ready   = (r_state == ST_FILL);
    assign w_fill_acc = in_ready & in_valid;

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_fifo[r_rd_ptr];
    assign w_pop     = out_valid & out_ready;
    assign w_push    = r_inflight;

    // Credit the pop happening this cycle so a steady out_ready gives one
    // word per cycle; the buffer still never holds more than two words.
    assign w_occ_eff  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_issue = (r_state == ST_DUMP) && (r_rem != {LW{1'b0}}) && (w_occ_eff < 3'd2);

    // Last buffered word leaves this cycle and nothing else is on its way.
    assign w_drained = ~r_inflight & ((r_count == 2'd0) | ((r_count == 2'd1) & w_pop));

    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign mem_chipselect = w_fill_acc | w_rd_issue;
    assign mem_write      = w_fill_acc;
    assign mem_address    = r_addr;
    assign mem_writedata  = w_fill_acc ? in_data : 32'h0000_0000;

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign err  = r_err;

    // Next-state and completion/rejection pulse decode.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_acc) begin
                    if (w_range_bad) begin
                        w_err_next = 1'b1;
                    end else if (w_len_zero) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_load = 1'b1;
                        if (cmd_write) begin
                            w_state_next = ST_FILL;
                        end else begin
                            w_state_next = ST_DUMP;
                        end
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_fill_acc && w_rem_last) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = ST_FILL;
                end
            end
            ST_DUMP: begin
                if (w_rd_issue && w_rem_last) begin
                    w_state_next = ST_FLUSH;
                end else begin
                    w_state_next = ST_DUMP;
                end
            end
            ST_FLUSH: begin
                if (w_drained) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = ST_FLUSH;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and registered done/err pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    // Word address and remaining-word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= {AW{1'b0}};
            r_rem  <= {LW{1'b0}};
        end else if (w_load) begin
            r_addr <= cmd_base;
            r_rem  <= cmd_len;
        end else if (w_fill_acc || w_rd_issue) begin
            r_addr <= r_addr + {{(AW-1){1'b0}}, 1'b1};
            r_rem  <= r_rem - {{(LW-1){1'b0}}, 1'b1};
        end else begin
            r_addr <= r_addr;
            r_rem  <= r_rem;
        end
    end

    // Read-in-flight flag and the 2-entry dump buffer (push and pop may coincide).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_fifo[0]  <= 32'h0000_0000;
            r_fifo[1]  <= 32'h0000_0000;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_rd_issue;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= mem_readdata;
                r_wr_ptr         <= ~r_wr_ptr;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_data_mem_stream_loader.sv
module tb_data_mem_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [12:0] cmd_base;
    logic [13:0] cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic        busy;
    logic        done;
    logic        err;

    data_mem_stream_loader dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, registered read data (1-cycle latency).
    logic [31:0] mem_m [0:6143];
    logic [31:0] mem_rd;
    always @(posedge clk) begin
        if (mem_chipselect && mem_write) mem_m[mem_address] <= mem_writedata;
        else if (mem_chipselect)         mem_rd <= mem_m[mem_address];
    end
    assign mem_readdata = mem_rd;

    // Scoreboard queues and the bench's own view of memory contents.
    logic [12:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [12:0] ra_q[$];
    logic [31:0] od_q[$];
    logic        ev_q[$];   // 0 = done expected, 1 = err expected
    logic [31:0] exp_mem [0:6143];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows an access or a word.
    int occ_m  = 0;
    int infl_m = 0;
    initial begin
        logic pop;
        logic issue;
        forever begin
            @(negedge clk);
            if (reset) begin
                occ_m  = 0;
                infl_m = 0;
                if (mem_chipselect) chk("cs_during_reset", 32'(mem_chipselect), 32'd0);
            end else begin
                pop   = out_valid & out_ready;
                issue = mem_chipselect & ~mem_write;
                if (mem_write && !mem_chipselect) chk("write_without_cs", 32'd1, 32'd0);
                if (mem_chipselect && mem_write) begin
                    if (wa_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                    else begin
                        chk("wr_addr", 32'(mem_address), 32'(wa_q.pop_front()));
                        chk("wr_data", mem_writedata, wd_q.pop_front());
                    end
                end
                if (issue) begin
                    if (ra_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
                    else chk("rd_addr", 32'(mem_address), 32'(ra_q.pop_front()));
                    chk("rd_credit", 32'((occ_m + infl_m - 32'(pop)) < 2), 32'd1);
                end
                if (out_valid || occ_m > 0) chk("out_valid_model", 32'(out_valid), 32'(occ_m > 0));
                if (pop) begin
                    if (od_q.size() == 0) chk("unexpected_word", out_data, 32'hFFFF_FFFF);
                    else chk("out_data", out_data, od_q.pop_front());
                end
                if (done) begin
                    if (ev_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                    else chk("ev_done", 32'd0, 32'(ev_q.pop_front()));
                end
                if (err) begin
                    if (ev_q.size() == 0) chk("unexpected_err", 32'd1, 32'd0);
                    else chk("ev_err", 32'd1, 32'(ev_q.pop_front()));
                end
                occ_m  = occ_m + infl_m - 32'(pop);
                infl_m = 32'(issue);
            end
        end
    end

    // Presents a command; returns #1 after the accepting clock edge.
    task automatic issue_cmd(input logic wr, input logic [12:0] base, input logic [13:0] len);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_base = base; cmd_len = len;
        @(negedge clk);
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [12:0] base, input logic [13:0] len, input logic [31:0] first);
        for (int i = 0; i < int'(len); i++) begin
            wa_q.push_back(base + 13'(i));
            wd_q.push_back(first + 32'(i));
            exp_mem[int'(base) + i] = first + 32'(i);
        end
        ev_q.push_back(1'b0);
        issue_cmd(1'b1, base, len);
        for (int i = 0; i < int'(len); i++) begin
            in_valid = 1'b1;
            in_data  = first + 32'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("fill_done_timing", 32'(done), 32'd1);
        chk("fill_busy_after", 32'(busy), 32'd0);
    endtask

    // mode 0: out_ready held high with exact latency checks; mode 1: 1,0,0,1 pattern.
    task automatic do_dump(input logic [12:0] base, input logic [13:0] len, input int mode);
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        for (int i = 0; i < int'(len); i++) begin
            ra_q.push_back(base + 13'(i));
            od_q.push_back(exp_mem[int'(base) + i]);
        end
        ev_q.push_back(1'b0);
        out_ready = (mode == 0) ? 1'b1 : pat[0];
        issue_cmd(1'b0, base, len);
        if (mode == 0) begin
            @(negedge clk); chk("dump_lat_c1", 32'(out_valid), 32'd0);
            @(negedge clk); chk("dump_lat_c2", 32'(out_valid), 32'd0);
            for (int i = 0; i < int'(len); i++) begin
                @(negedge clk); chk("dump_stream_valid", 32'(out_valid), 32'd1);
            end
            @(negedge clk); chk("dump_done_timing", 32'(done), 32'd1);
            @(posedge clk); #1;
        end else begin
            k = 0;
            while (k < 300 && ev_q.size() != 0) begin
                out_ready = pat[k % 4];
                @(posedge clk); #1;
                k++;
            end
            if (ev_q.size() != 0) chk("dump_timeout", 32'd1, 32'd0);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = 13'd0; cmd_len = 14'd0;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        #3;
        chk("rst_cs",     32'(mem_chipselect), 32'd0);
        chk("rst_write",  32'(mem_write),      32'd0);
        chk("rst_be",     32'(mem_byteenable), 32'hF);
        chk("rst_clken",  32'(mem_clken),      32'd1);
        chk("rst_busy",   32'(busy),           32'd0);
        chk("rst_done",   32'(done),           32'd0);
        chk("rst_err",    32'(err),            32'd0);
        chk("rst_ovalid", 32'(out_valid),      32'd0);
        chk("rst_iready", 32'(in_ready),       32'd0);
        chk("rst_cready", 32'(cmd_ready),      32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_cready", 32'(cmd_ready), 32'd1);

        // Basic fill then dump at full rate
        do_fill(13'h010, 14'd4, 32'h0000_00A0);
        do_dump(13'h010, 14'd4, 0);

        // Backpressured dump of 8 words
        do_fill(13'h100, 14'd8, 32'h0000_00B0);
        do_dump(13'h100, 14'd8, 1);

        // Rejected range and zero length
        ev_q.push_back(1'b1);
        issue_cmd(1'b0, 13'd6140, 14'd5);
        @(negedge clk);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy",  32'(busy), 32'd0);
        ev_q.push_back(1'b0);
        issue_cmd(1'b1, 13'd0, 14'd0);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);

        // Last legal word
        do_fill(13'd6143, 14'd1, 32'h0000_00C0);
        do_dump(13'd6143, 14'd1, 1);

        // Reset during a dump with one word buffered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) ra_q.push_back(13'h010 + 13'(i));
        issue_cmd(1'b0, 13'h010, 14'd4);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("pre_reset_buffered", 32'(out_valid), 32'd1);
        chk("pre_reset_head",     out_data, 32'h0000_00A0);
        #2 reset = 1'b1;
        #1;
        chk("async_ovalid", 32'(out_valid),      32'd0);
        chk("async_cs",     32'(mem_chipselect), 32'd0);
        chk("async_busy",   32'(busy),           32'd0);
        chk("async_odata",  out_data,            32'd0);
        wa_q.delete(); wd_q.delete(); ra_q.delete(); od_q.delete(); ev_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        do_dump(13'd6143, 14'd1, 0);
        do_fill(13'h020, 14'd2, 32'h0000_00D0);
        do_dump(13'h020, 14'd2, 1);

        repeat (3) @(posedge clk);
        chk("left_wr",  32'(wa_q.size()), 32'd0);
        chk("left_rd",  32'(ra_q.size()), 32'd0);
        chk("left_out", 32'(od_q.size()), 32'd0);
        chk("left_ev",  32'(ev_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
